// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared types, PLAN constants and saturation helper for the activation unit
package activation_pkg;

    typedef enum logic {
        LOGISTIC = 1'b0,
        RELU     = 1'b1
    } kind_t;

    // PLAN breakpoints and offsets in units of 1/32. Shifting one left by
    // ARG_FRAC gives its value in Q.(ARG_FRAC+5), the exact working format of
    // the logistic datapath; plan_scale() gives it in Q.ARG_FRAC.
    localparam int PLAN_Q       = 5;
    localparam int PLAN_ONE     = 32;   // 1.0
    localparam int PLAN_BP_SAT  = 160;  // 5.0
    localparam int PLAN_BP_HI   = 76;   // 2.375
    localparam int PLAN_BP_LO   = 32;   // 1.0
    localparam int PLAN_OFS_HI  = 27;   // 0.84375
    localparam int PLAN_OFS_MID = 20;   // 0.625
    localparam int PLAN_OFS_LO  = 16;   // 0.5

    function automatic int plan_scale(input int q5, input int frac);
        return (q5 << frac) >>> PLAN_Q;
    endfunction

    // Clamp to the range of a width-bit signed or unsigned number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width,
                                                    input logic is_signed);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = is_signed ? ((64'sd1 <<< (width - 1)) - 64'sd1) : ((64'sd1 <<< width) - 64'sd1);
        lo = is_signed ? -(64'sd1 <<< (width - 1)) : 64'sd0;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/activation_store.sv
// rtl/activation_store.sv - in-order store of {kind, activation} awaiting back-propagated feedback
// Ports: clock, reset (async active-low), push/push_data, pop/pop_data (head, valid when !empty),
//        count (occupancy), full, empty.
module activation_store
    import activation_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/activation.sv
// rtl/activation.sv - handshaked logistic/ReLU activation with training store and local delta
// Ports: clock, reset (async active-low); train, kind sampled with the argument;
//        argument_* in / activation_* out (forward); feedback_* in / delta_* out (backward);
//        pending = stored activations awaiting feedback.
module activation
    import activation_pkg::*;
#(
    parameter int ARG_W    = 16,
    parameter int ARG_FRAC = 8,
    parameter int ACT_W    = 8,
    parameter int DEPTH    = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         train,
    input  logic                         kind,
    input  logic                         argument_valid,
    output logic                         argument_ready,
    input  logic [ARG_W-1:0]             argument_data,
    output logic                         activation_valid,
    input  logic                         activation_ready,
    output logic [ACT_W-1:0]             activation_data,
    input  logic                         feedback_valid,
    output logic                         feedback_ready,
    input  logic [ARG_W-1:0]             feedback_data,
    output logic                         delta_valid,
    input  logic                         delta_ready,
    output logic [ARG_W-1:0]             delta_data,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int YW    = ARG_FRAC + PLAN_Q + 2;

    localparam logic [ARG_W-1:0] BP_SAT = ARG_W'(plan_scale(PLAN_BP_SAT, ARG_FRAC));
    localparam logic [ARG_W-1:0] BP_HI  = ARG_W'(plan_scale(PLAN_BP_HI, ARG_FRAC));
    localparam logic [ARG_W-1:0] BP_LO  = ARG_W'(plan_scale(PLAN_BP_LO, ARG_FRAC));
    localparam logic [YW-1:0]    ONE_Y  = YW'(PLAN_ONE << ARG_FRAC);
    localparam logic [YW-1:0]    OFS_HI = YW'(PLAN_OFS_HI << ARG_FRAC);
    localparam logic [YW-1:0]    OFS_MD = YW'(PLAN_OFS_MID << ARG_FRAC);
    localparam logic [YW-1:0]    OFS_LO = YW'(PLAN_OFS_LO << ARG_FRAC);
    localparam logic signed [ARG_W-1:0] RELU_ONE = ARG_W'(1 << ARG_FRAC);

    logic                     arg_fire;
    logic                     fb_fire;
    logic                     store_full;
    logic                     store_empty;
    logic [ACT_W:0]           head;
    logic signed [ARG_W-1:0]  x;
    logic [ARG_W-1:0]         mag;
    logic [YW-1:0]            mag_y;
    logic [YW-1:0]            f_y;
    logic [YW-1:0]            y_y;
    logic [ACT_W-1:0]         logistic_act;
    logic [ACT_W-1:0]         relu_act;
    logic [ACT_W-1:0]         act_next;
    logic [ACT_W-1:0]         head_act;
    logic [ACT_W-1:0]         inv_act;
    kind_t                    head_kind;
    logic [2*ACT_W-1:0]       g;
    logic signed [63:0]       fb_ext;
    logic signed [63:0]       g_ext;
    logic signed [63:0]       prod;
    logic [ARG_W-1:0]         delta_next;

    assign argument_ready = (!activation_valid || activation_ready) && (!train || !store_full);
    assign feedback_ready = !store_empty && (!delta_valid || delta_ready);
    assign arg_fire       = argument_valid && argument_ready;
    assign fb_fire        = feedback_valid && feedback_ready;
    assign x              = argument_data;

    // Forward path. The logistic is evaluated in Q.(ARG_FRAC+5) so the /32
    // segment and the 1-f reflection are exact before the final truncation.
    always_comb begin
        mag   = argument_data[ARG_W-1] ? -argument_data : argument_data;
        mag_y = YW'(mag);
        f_y   = ONE_Y;
        if (mag >= BP_SAT)     f_y = ONE_Y;
        else if (mag >= BP_HI) f_y = mag_y + OFS_HI;
        else if (mag >= BP_LO) f_y = (mag_y << 2) + OFS_MD;
        else                   f_y = (mag_y << 3) + OFS_LO;
        y_y = argument_data[ARG_W-1] ? ONE_Y - f_y : f_y;
        logistic_act = ACT_W'(saturate(64'(y_y >> (ARG_FRAC + PLAN_Q - ACT_W)), ACT_W, 1'b0));

        relu_act = ACT_W'(argument_data >> (ARG_FRAC - ACT_W));
        if (x[ARG_W-1] || x == '0) relu_act = '0;
        else if (x >= RELU_ONE)    relu_act = '1;

        act_next = (kind_t'(kind) == RELU) ? relu_act : logistic_act;
    end

    // Backward path: the derivative comes from the oldest stored activation.
    always_comb begin
        head_act  = head[ACT_W-1:0];
        head_kind = kind_t'(head[ACT_W]);
        inv_act   = ~head_act;
        g         = (2*ACT_W)'(head_act) * (2*ACT_W)'(inv_act);
        fb_ext    = {{(64-ARG_W){feedback_data[ARG_W-1]}}, feedback_data};
        g_ext     = {{(64-2*ACT_W){1'b0}}, g};
        prod      = fb_ext * g_ext;
        if (head_kind == RELU) delta_next = (head_act != '0) ? feedback_data : '0;
        else                   delta_next = ARG_W'(saturate(prod >>> (2*ACT_W), ARG_W, 1'b1));
    end

    activation_store #(
        .DEPTH (DEPTH),
        .WIDTH (ACT_W + 1),
        .CNT_W (CNT_W)
    ) u_store (
        .clock     (clock),
        .reset     (reset),
        .push      (arg_fire && train),
        .push_data ({kind, act_next}),
        .pop       (fb_fire),
        .pop_data  (head),
        .count     (pending),
        .full      (store_full),
        .empty     (store_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            activation_valid <= 1'b0;
            activation_data  <= '0;
        end else if (arg_fire) begin
            activation_valid <= 1'b1;
            activation_data  <= act_next;
        end else if (activation_ready) begin
            activation_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            delta_valid <= 1'b0;
            delta_data  <= '0;
        end else if (fb_fire) begin
            delta_valid <= 1'b1;
            delta_data  <= delta_next;
        end else if (delta_ready) begin
            delta_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_activation.sv
// tb/tb_activation.sv - scoreboard bench for the activation unit
module tb_activation;

    localparam int ARG_W    = 16;
    localparam int ARG_FRAC = 8;
    localparam int ACT_W    = 8;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int BUDGET   = 200;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             train = 1'b0;
    logic             kind = 1'b0;
    logic             argument_valid = 1'b0;
    logic             argument_ready;
    logic [ARG_W-1:0] argument_data = '0;
    logic             activation_valid;
    logic             activation_ready = 1'b1;
    logic [ACT_W-1:0] activation_data;
    logic             feedback_valid = 1'b0;
    logic             feedback_ready;
    logic [ARG_W-1:0] feedback_data = '0;
    logic             delta_valid;
    logic             delta_ready = 1'b1;
    logic [ARG_W-1:0] delta_data;
    logic [CNT_W-1:0] pending;

    activation #(
        .ARG_W(ARG_W), .ARG_FRAC(ARG_FRAC), .ACT_W(ACT_W), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .train(train), .kind(kind),
        .argument_valid(argument_valid), .argument_ready(argument_ready),
        .argument_data(argument_data),
        .activation_valid(activation_valid), .activation_ready(activation_ready),
        .activation_data(activation_data),
        .feedback_valid(feedback_valid), .feedback_ready(feedback_ready),
        .feedback_data(feedback_data),
        .delta_valid(delta_valid), .delta_ready(delta_ready), .delta_data(delta_data),
        .pending(pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;
        int act;
    } entry_t;

    int     act_q[$];
    int     dlt_q[$];
    entry_t store_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_stored = 0;
    int     act_mode = 0;
    int     dlt_mode = 0;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, got, got, want, want, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no handshake within %0d cycles, required acceptance", name, BUDGET);
    endtask

    function automatic int model_logistic(input int xi);
        real v, av, f, y;
        int r;
        v  = xi / 256.0;
        av = (v < 0.0) ? -v : v;
        if (av >= 5.0)        f = 1.0;
        else if (av >= 2.375) f = av / 32.0 + 0.84375;
        else if (av >= 1.0)   f = av / 8.0 + 0.625;
        else                  f = av / 4.0 + 0.5;
        y = (v < 0.0) ? 1.0 - f : f;
        r = int'($floor(y * 256.0));
        if (r > 255) r = 255;
        if (r < 0) r = 0;
        return r;
    endfunction

    function automatic int model_relu(input int xi);
        real v;
        v = xi / 256.0;
        if (v <= 0.0) return 0;
        if (v >= 1.0) return 255;
        return int'($floor(v * 256.0));
    endfunction

    function automatic int model_delta(input entry_t e, input int fb);
        real r;
        int d;
        if (e.kind == 1) return (e.act != 0) ? fb : 0;
        r = $floor(real'(fb) * real'(e.act) * real'(255 - e.act) / 65536.0);
        d = int'(r);
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        return d;
    endfunction

    // Scoreboard/monitor: sampled on the falling edge, between driver updates.
    always @(negedge clock) begin
        bit     exp_av, exp_dv, exp_ar, exp_fr;
        entry_t e;
        int     xi, a;
        if (!reset) begin
            act_q.delete();
            dlt_q.delete();
            store_q.delete();
            chk("rst_activation_valid", activation_valid, 0);
            chk("rst_activation_data", activation_data, 0);
            chk("rst_delta_valid", delta_valid, 0);
            chk("rst_delta_data", delta_data, 0);
            chk("rst_pending", pending, 0);
            chk("rst_argument_ready", argument_ready, 1);
            chk("rst_feedback_ready", feedback_ready, 0);
        end else begin
            exp_av = (act_q.size() != 0);
            exp_dv = (dlt_q.size() != 0);
            exp_ar = (!exp_av || activation_ready) && (!train || store_q.size() < DEPTH);
            exp_fr = (store_q.size() > 0) && (!exp_dv || delta_ready);
            chk("activation_valid", activation_valid, exp_av);
            chk("delta_valid", delta_valid, exp_dv);
            chk("pending", pending, store_q.size());
            chk("argument_ready", argument_ready, exp_ar);
            chk("feedback_ready", feedback_ready, exp_fr);
            if (activation_valid && exp_av) begin
                chk("activation_data", activation_data, act_q[0]);
                if (activation_ready) void'(act_q.pop_front());
            end
            if (delta_valid && exp_dv) begin
                chk("delta_data", longint'($signed(delta_data)), dlt_q[0]);
                if (delta_ready) void'(dlt_q.pop_front());
            end
            if (feedback_valid && feedback_ready && store_q.size() > 0) begin
                e = store_q.pop_front();
                dlt_q.push_back(model_delta(e, int'($signed(feedback_data))));
            end
            if (argument_valid && argument_ready) begin
                xi = int'($signed(argument_data));
                a  = kind ? model_relu(xi) : model_logistic(xi);
                act_q.push_back(a);
                if (train) store_q.push_back('{int'(kind), a});
            end
        end
    end

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 2) return 1'b0;
        return ($urandom_range(0, 9) < 7);
    endfunction

    initial forever begin
        @(posedge clock);
        #1;
        activation_ready = pick_ready(act_mode);
        delta_ready      = pick_ready(dlt_mode);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_arg(input logic tr, input logic kd, input logic [ARG_W-1:0] d);
        bit ok;
        ok = 0;
        train = tr;
        kind = kd;
        argument_data = d;
        argument_valid = 1'b1;
        for (int w = 0; w < BUDGET; w++) begin
            @(negedge clock);
            if (argument_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("argument_accept");
        @(posedge clock);
        #1;
        argument_valid = 1'b0;
        if (ok && tr) n_stored++;
    endtask

    task automatic send_fb(input logic [ARG_W-1:0] d);
        bit ok;
        ok = 0;
        feedback_data = d;
        feedback_valid = 1'b1;
        for (int w = 0; w < BUDGET; w++) begin
            @(negedge clock);
            if (feedback_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("feedback_accept");
        @(posedge clock);
        #1;
        feedback_valid = 1'b0;
        if (ok) n_stored--;
    endtask

    logic [ARG_W-1:0] bnd_vals [14] = '{16'h0500, 16'h04FF, 16'h0260, 16'h025F, 16'h0100, 16'h00FF,
                                        16'hFB00, 16'hFB01, 16'hFDA0, 16'hFF00, 16'h8000, 16'h7FFF,
                                        16'h0001, 16'hFFFF};

    function automatic logic [ARG_W-1:0] rand_arg();
        int v;
        case ($urandom_range(0, 3))
            0: return ARG_W'($urandom);
            1: begin v = int'($urandom_range(0, 3072)) - 1536; return ARG_W'(v); end
            2: return bnd_vals[$urandom_range(0, 13)];
            default: begin v = int'($urandom_range(0, 320)) - 32; return ARG_W'(v); end
        endcase
    endfunction

    function automatic logic [ARG_W-1:0] rand_fb();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            default: return ARG_W'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        send_arg(1'b0, 1'b0, 16'h0000);
        send_arg(1'b1, 1'b0, 16'h0600);
        send_fb(16'hFE00);
        send_arg(1'b1, 1'b0, 16'h0000);
        send_fb(16'h0100);
        send_arg(1'b1, 1'b0, 16'hFA00);
        send_fb(16'h0100);
        send_arg(1'b1, 1'b1, 16'hFF00);
        send_arg(1'b1, 1'b1, 16'h0080);
        send_arg(1'b1, 1'b1, 16'h0200);
        repeat (3) send_fb(16'h0300);

        // Fill the store, then feedback with an argument waiting on it.
        for (int i = 0; i < DEPTH; i++) send_arg(1'b1, 1'($urandom_range(0, 1)), rand_arg());
        idle(2);
        fork
            send_fb(16'h0100);
            send_arg(1'b1, 1'b1, 16'h0040);
        join
        send_fb(16'hFF00);
        fork
            send_fb(16'h0200);
            send_arg(1'b1, 1'b0, 16'h0180);
        join
        while (n_stored > 0) send_fb(rand_fb());

        act_mode = 1;
        dlt_mode = 1;
        for (int i = 0; i < 300; i++) begin
            bit do_arg, do_fb, tr, kd;
            do_fb  = (n_stored > 0) && ($urandom_range(0, 2) == 0);
            do_arg = ($urandom_range(0, 3) != 0);
            tr     = 1'($urandom_range(0, 1));
            kd     = 1'($urandom_range(0, 1));
            if (tr && n_stored >= DEPTH && !do_fb) tr = 1'b0;
            if (do_arg && do_fb) begin
                fork
                    send_arg(tr, kd, rand_arg());
                    send_fb(rand_fb());
                join
            end else if (do_arg) begin
                send_arg(tr, kd, rand_arg());
            end else if (do_fb) begin
                send_fb(rand_fb());
            end else begin
                idle(1);
            end
        end
        act_mode = 0;
        dlt_mode = 0;
        while (n_stored > 0) send_fb(rand_fb());
        idle(3);
        chk("activations_drained", act_q.size(), 0);
        chk("deltas_drained", dlt_q.size(), 0);

        // Backpressure: output held, second argument refused, then reset mid-hold.
        act_mode = 2;
        idle(1);
        send_arg(1'b1, 1'b0, 16'h0123);
        train = 1'b0;
        kind = 1'b1;
        argument_data = 16'h0080;
        argument_valid = 1'b1;
        idle(5);
        reset = 1'b0;
        argument_valid = 1'b0;
        n_stored = 0;
        idle(2);
        reset = 1'b1;
        act_mode = 0;
        idle(1);
        send_arg(1'b0, 1'b0, 16'h0100);
        idle(3);
        chk("post_reset_drained", act_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
